// File: rtl/miinst_queue_if.sv
// Micro-instruction types and the fetch/decode handshake bundle around miinst_queue.
// Master is the fetch/decode side; slave is the queue itself.
package miinst_pkg;
  typedef enum logic [3:0] {
    MIOP_NOP  = 4'd0,
    MIOP_ADDI = 4'd1,
    MIOP_S    = 4'd2,
    MIOP_L    = 4'd3,
    MIOP_JR   = 4'd4
  } miop_t;

  typedef struct packed {
    miop_t       op;
    logic [31:0] pc;
    logic [7:0]  bmd;
  } miinst_t;

  localparam miinst_t MIINST_NOP = '{op: MIOP_NOP, pc: 32'd0, bmd: 8'd0};
endpackage

interface miinst_queue_if #(
  parameter int MQ_N  = 4,
  parameter int CNT_W = 5
);
  logic                               in_valid;
  miinst_pkg::miinst_t [MQ_N-1:0]     in_miinst;
  logic                               in_ready;
  logic                               out_valid;
  miinst_pkg::miinst_t                out_miinst;
  logic                               out_ready;
  logic                               flush;
  logic [CNT_W-1:0]                   count;

  modport master (
    output in_valid, in_miinst, out_ready, flush,
    input  in_ready, out_valid, out_miinst, count
  );

  modport slave (
    input  in_valid, in_miinst, out_ready, flush,
    output in_ready, out_valid, out_miinst, count
  );
endinterface

// File: rtl/miinst_queue.sv
// Micro-instruction queue: packs the non-NOP slots of each fetch bundle into a
// circular buffer and issues one entry per cycle to decode.
module miinst_queue
  import miinst_pkg::*;
#(
  parameter int MQ_N  = 4,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input logic          clk,
  input logic          rst,
  miinst_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);

  miinst_t           mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  n_enq;
  logic [PTR_W-1:0]  slot_off [MQ_N];
  logic [MQ_N-1:0]   slot_live;
  logic              enq;
  logic              deq;

  // Each live slot lands at tail plus the number of live slots before it,
  // which squeezes out the NOP gaps while keeping slot order.
  always_comb begin
    n_enq = '0;
    for (int i = 0; i < MQ_N; i++) begin
      slot_live[i] = (q.in_miinst[i].op != MIOP_NOP);
      slot_off[i]  = n_enq[PTR_W-1:0];
      n_enq        = n_enq + CNT_W'(slot_live[i]);
    end
  end

  assign q.in_ready   = (CNT_W'(DEPTH) - cnt) >= CNT_W'(MQ_N);
  assign q.out_valid  = (cnt != '0);
  assign q.out_miinst = q.out_valid ? mem[head] : MIINST_NOP;
  assign q.count      = cnt;

  assign enq = q.in_valid & q.in_ready & ~q.flush;
  assign deq = q.out_valid & q.out_ready & ~q.flush;

  always_ff @(posedge clk) begin
    if (enq) begin
      for (int i = 0; i < MQ_N; i++) begin
        if (slot_live[i]) mem[tail + slot_off[i]] <= q.in_miinst[i];
      end
    end
  end

  // Power-of-two depth lets the pointers wrap for free, even mid-bundle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (q.flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (enq) tail <= tail + n_enq[PTR_W-1:0];
      if (deq) head <= head + PTR_W'(1);
      cnt <= cnt + (enq ? n_enq : CNT_W'(0)) - CNT_W'(deq);
    end
  end
endmodule

// File: tb/tb_miinst_queue.sv
// Directed bench for miinst_queue: packing, backpressure, wrap, flush and async reset.
module tb_miinst_queue;
  import miinst_pkg::*;

  localparam int MQ_N  = 4;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  typedef miinst_t [MQ_N-1:0] bundle_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  miinst_queue_if #(.MQ_N(MQ_N), .CNT_W(CNT_W)) bus ();

  miinst_queue #(.MQ_N(MQ_N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic miinst_t mi(input miop_t op, input logic [31:0] pc, input logic [7:0] bmd);
    miinst_t m;
    m.op  = op;
    m.pc  = pc;
    m.bmd = bmd;
    return m;
  endfunction

  function automatic bundle_t mkb(input miinst_t s0, input miinst_t s1, input miinst_t s2, input miinst_t s3);
    bundle_t b;
    b[0] = s0;
    b[1] = s1;
    b[2] = s2;
    b[3] = s3;
    return b;
  endfunction

  // Drive at the falling edge, let one rising edge pass, return at the next falling edge.
  task automatic applyStimulus(input logic iv, input bundle_t b, input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.in_miinst = b;
    bus.out_ready = ordy;
    bus.flush     = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic bundle_t fullBundle(input logic [31:0] base);
    return mkb(mi(MIOP_ADDI, base, 8'h0), mi(MIOP_ADDI, base + 32'd4, 8'h1),
               mi(MIOP_ADDI, base + 32'd8, 8'h2), mi(MIOP_ADDI, base + 32'd12, 8'h3));
  endfunction

  always @(negedge clk) begin
    if (!rst) checkOutput("count_range", 64'(bus.count <= CNT_W'(DEPTH)), 64'd1);
  end

  initial begin
    bundle_t nopb;
    nopb = mkb(MIINST_NOP, MIINST_NOP, MIINST_NOP, MIINST_NOP);
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_miinst = nopb;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;

    // reset then idle
    @(negedge clk);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("rst_count", 64'(bus.count), 64'd0);
    checkOutput("rst_out_miinst", 64'(bus.out_miinst), 64'(MIINST_NOP));
    rst = 1'b0;
    applyStimulus(1'b0, nopb, 1'b0, 1'b0);
    checkOutput("idle_out_valid", 64'(bus.out_valid), 64'd0);

    // {ADDI, S, NOP, NOP}
    applyStimulus(1'b1, mkb(mi(MIOP_ADDI, 32'h100, 8'h11), mi(MIOP_S, 32'h104, 8'h22),
                            MIINST_NOP, MIINST_NOP), 1'b0, 1'b0);
    checkOutput("b1_count", 64'(bus.count), 64'd2);
    checkOutput("b1_op", 64'(bus.out_miinst.op), 64'(MIOP_ADDI));
    checkOutput("b1_pc", 64'(bus.out_miinst.pc), 64'h100);
    applyStimulus(1'b0, nopb, 1'b1, 1'b0);
    checkOutput("b1_pop_op", 64'(bus.out_miinst.op), 64'(MIOP_S));
    checkOutput("b1_pop_count", 64'(bus.count), 64'd1);
    applyStimulus(1'b0, nopb, 1'b1, 1'b0);
    checkOutput("b1_empty_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("b1_empty_op", 64'(bus.out_miinst.op), 64'(MIOP_NOP));

    // {NOP, L, NOP, JR}
    applyStimulus(1'b1, mkb(MIINST_NOP, mi(MIOP_L, 32'h200, 8'h33),
                            MIINST_NOP, mi(MIOP_JR, 32'h20C, 8'h5A)), 1'b0, 1'b0);
    checkOutput("b2_count", 64'(bus.count), 64'd2);
    checkOutput("b2_op_l", 64'(bus.out_miinst.op), 64'(MIOP_L));
    applyStimulus(1'b0, nopb, 1'b1, 1'b0);
    checkOutput("b2_op_jr", 64'(bus.out_miinst.op), 64'(MIOP_JR));
    checkOutput("b2_jr_pc", 64'(bus.out_miinst.pc), 64'h20C);
    checkOutput("b2_jr_bmd", 64'(bus.out_miinst.bmd), 64'h5A);
    applyStimulus(1'b0, nopb, 1'b1, 1'b0);
    checkOutput("b2_empty", 64'(bus.count), 64'd0);

    // fill to DEPTH, hold a fifth bundle, then pop back below the threshold
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, fullBundle(32'h300 + 32'(16 * k)), 1'b0, 1'b0);
      if (k == 2) checkOutput("fill_ready_at12", 64'(bus.in_ready), 64'd1);
    end
    checkOutput("full_count", 64'(bus.count), 64'd16);
    checkOutput("full_in_ready", 64'(bus.in_ready), 64'd0);
    applyStimulus(1'b1, fullBundle(32'h900), 1'b0, 1'b0);
    checkOutput("held_count", 64'(bus.count), 64'd16);
    checkOutput("held_head_pc", 64'(bus.out_miinst.pc), 64'h300);
    applyStimulus(1'b0, nopb, 1'b1, 1'b0);
    checkOutput("pop1_count", 64'(bus.count), 64'd15);
    checkOutput("pop1_in_ready", 64'(bus.in_ready), 64'd0);
    checkOutput("pop1_pc", 64'(bus.out_miinst.pc), 64'h304);
    for (int n = 0; n < 3; n++) applyStimulus(1'b0, nopb, 1'b1, 1'b0);
    checkOutput("pop4_count", 64'(bus.count), 64'd12);
    checkOutput("pop4_in_ready", 64'(bus.in_ready), 64'd1);
    for (int n = 4; n < 16; n++) begin
      checkOutput("drain_pc", 64'(bus.out_miinst.pc), 64'(32'h300 + 32'(4 * n)));
      applyStimulus(1'b0, nopb, 1'b1, 1'b0);
    end
    checkOutput("drain_count", 64'(bus.count), 64'd0);

    // flush on empty, then walk the pointers to 14 and wrap a bundle across the end
    applyStimulus(1'b0, nopb, 1'b0, 1'b1);
    checkOutput("flush_empty_valid", 64'(bus.out_valid), 64'd0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, fullBundle(32'h400 + 32'(16 * k)), 1'b0, 1'b0);
    applyStimulus(1'b1, mkb(mi(MIOP_S, 32'h430, 8'h0), MIINST_NOP,
                            mi(MIOP_S, 32'h434, 8'h0), MIINST_NOP), 1'b0, 1'b0);
    checkOutput("pre14_count", 64'(bus.count), 64'd14);
    checkOutput("pre14_in_ready", 64'(bus.in_ready), 64'd0);
    for (int n = 0; n < 14; n++) applyStimulus(1'b0, nopb, 1'b1, 1'b0);
    checkOutput("pre14_drained", 64'(bus.count), 64'd0);
    applyStimulus(1'b1, fullBundle(32'h500), 1'b0, 1'b0);
    checkOutput("wrap_count", 64'(bus.count), 64'd4);
    for (int n = 0; n < 4; n++) begin
      checkOutput("wrap_pc", 64'(bus.out_miinst.pc), 64'(32'h500 + 32'(4 * n)));
      applyStimulus(1'b0, nopb, 1'b1, 1'b0);
      checkOutput("wrap_cnt", 64'(bus.count), 64'(3 - n));
    end

    // flush beats a same-cycle bundle and pop
    applyStimulus(1'b1, fullBundle(32'h600), 1'b0, 1'b0);
    applyStimulus(1'b1, mkb(MIINST_NOP, MIINST_NOP, mi(MIOP_L, 32'h610, 8'h0), MIINST_NOP), 1'b0, 1'b0);
    checkOutput("pre_flush_count", 64'(bus.count), 64'd5);
    applyStimulus(1'b1, mkb(mi(MIOP_L, 32'h680, 8'h0), MIINST_NOP,
                            mi(MIOP_S, 32'h684, 8'h0), mi(MIOP_JR, 32'h688, 8'h0)), 1'b1, 1'b1);
    checkOutput("flush_count", 64'(bus.count), 64'd0);
    checkOutput("flush_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("flush_op", 64'(bus.out_miinst.op), 64'(MIOP_NOP));
    applyStimulus(1'b1, mkb(MIINST_NOP, mi(MIOP_JR, 32'h7000, 8'hC3), MIINST_NOP, MIINST_NOP), 1'b0, 1'b0);
    checkOutput("post_flush_count", 64'(bus.count), 64'd1);
    checkOutput("post_flush_pc", 64'(bus.out_miinst.pc), 64'h7000);

    // asynchronous reset between clock edges
    applyStimulus(1'b1, fullBundle(32'h800), 1'b0, 1'b0);
    checkOutput("burst_count", 64'(bus.count), 64'd5);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("async_count", 64'(bus.count), 64'd0);
    checkOutput("async_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b0;
    applyStimulus(1'b0, nopb, 1'b0, 1'b0);
    checkOutput("after_rst_count", 64'(bus.count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
